// File: rtl/calc.sv
// Registered 4-bit calculator (add/sub/mul in one cycle, 4-step restoring divide).
// Define CALC_REM_EN to return {remainder, quotient} from divide instead of {0, quotient}.
module calc (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic [1:0] ops,
    output logic [7:0] total,
    output logic       valid,
    output logic       busy,
    output logic       div_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DIV  = 1'b1
    } state_t;

    state_t     state, state_n;
    logic [1:0] cnt, cnt_n;
    logic [3:0] rem, rem_n;
    logic [3:0] quo, quo_n;
    logic [3:0] dvs, dvs_n;
    logic [7:0] total_n;
    logic       valid_n;
    logic       div_err_n;

    logic [4:0] shifted;
    logic       ge;
    logic [3:0] step_rem;
    logic [3:0] step_quo;
    logic [7:0] div_result;

    // One restoring iteration: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted  = {rem, quo[3]};
        ge       = (shifted >= {1'b0, dvs});
        step_rem = ge ? (shifted[3:0] - dvs) : shifted[3:0];
        step_quo = {quo[2:0], ge};
`ifdef CALC_REM_EN
        div_result = {step_rem, step_quo};
`else
        div_result = {4'b0000, step_quo};
`endif
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        rem_n     = rem;
        quo_n     = quo;
        dvs_n     = dvs;
        total_n   = total;
        valid_n   = 1'b0;
        div_err_n = div_err;
        case (state)
            S_IDLE: begin
                if (en) begin
                    case (ops)
                        2'b00: begin
                            total_n   = {3'b000, {1'b0, in1} + {1'b0, in2}};
                            valid_n   = 1'b1;
                            div_err_n = 1'b0;
                        end
                        2'b01: begin
                            total_n   = {4'b0000, in1} - {4'b0000, in2};
                            valid_n   = 1'b1;
                            div_err_n = 1'b0;
                        end
                        2'b10: begin
                            total_n   = {4'b0000, in1} * {4'b0000, in2};
                            valid_n   = 1'b1;
                            div_err_n = 1'b0;
                        end
                        default: begin
                            if (in2 == 4'd0) begin
                                total_n   = 8'hFF;
                                valid_n   = 1'b1;
                                div_err_n = 1'b1;
                            end else begin
                                state_n = S_DIV;
                                cnt_n   = 2'd0;
                                rem_n   = 4'd0;
                                quo_n   = in1;
                                dvs_n   = in2;
                            end
                        end
                    endcase
                end
            end
            S_DIV: begin
                rem_n = step_rem;
                quo_n = step_quo;
                cnt_n = cnt + 2'd1;
                if (cnt == 2'd3) begin
                    state_n   = S_IDLE;
                    total_n   = div_result;
                    valid_n   = 1'b1;
                    div_err_n = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 2'd0;
            rem     <= 4'd0;
            quo     <= 4'd0;
            dvs     <= 4'd0;
            total   <= 8'd0;
            valid   <= 1'b0;
            div_err <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            rem     <= rem_n;
            quo     <= quo_n;
            dvs     <= dvs_n;
            total   <= total_n;
            valid   <= valid_n;
            div_err <= div_err_n;
        end
    end

    assign busy = (state == S_DIV);

endmodule

// File: tb/tb_calc.sv
// Self-checking bench for calc: directed cases followed by randomized traffic
// compared against a transaction-level reference model.
module tb_calc;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] in1;
    logic [3:0] in2;
    logic [1:0] ops;
    logic [7:0] total;
    logic       valid;
    logic       busy;
    logic       div_err;

    int checks;
    int failures;

    logic [7:0] m_total;
    logic       m_valid;
    logic       m_err;
    int         m_busy_left;
    logic [7:0] m_pending;

    calc dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .in1    (in1),
        .in2    (in2),
        .ops    (ops),
        .total  (total),
        .valid  (valid),
        .busy   (busy),
        .div_err(div_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] expectedResult(input logic [3:0] a, input logic [3:0] b,
                                                   input logic [1:0] o);
        int r;
        case (o)
            2'b00:   r = int'(a) + int'(b);
            2'b01:   r = int'(a) - int'(b);
            2'b10:   r = int'(a) * int'(b);
            default: begin
                if (b == 4'd0) r = 255;
`ifdef CALC_REM_EN
                else r = ((int'(a) % int'(b)) * 16) + (int'(a) / int'(b));
`else
                else r = int'(a) / int'(b);
`endif
            end
        endcase
        return r[7:0];
    endfunction

    task automatic checkAll(input string tag);
        checkOutput({tag, ".total"}, total, m_total);
        checkOutput({tag, ".valid"}, {7'd0, valid}, {7'd0, m_valid});
        checkOutput({tag, ".busy"}, {7'd0, busy}, {7'd0, (m_busy_left > 0)});
        checkOutput({tag, ".div_err"}, {7'd0, div_err}, {7'd0, m_err});
    endtask

    // Drive one cycle of inputs, advance the reference model at the edge, then check.
    task automatic applyStimulus(input logic e, input logic [3:0] a, input logic [3:0] b,
                                 input logic [1:0] o, input string tag);
        @(negedge clk);
        en  = e;
        in1 = a;
        in2 = b;
        ops = o;
        @(posedge clk);
        m_valid = 1'b0;
        if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) begin
                m_total = m_pending;
                m_valid = 1'b1;
                m_err   = 1'b0;
            end
        end else if (e) begin
            if (o == 2'b11 && b != 4'd0) begin
                m_busy_left = 4;
                m_pending   = expectedResult(a, b, o);
            end else begin
                m_total = expectedResult(a, b, o);
                m_valid = 1'b1;
                m_err   = (o == 2'b11);
            end
        end
        #1;
        checkAll(tag);
    endtask

    task automatic modelReset();
        m_total     = 8'd0;
        m_valid     = 1'b0;
        m_err       = 1'b0;
        m_busy_left = 0;
        m_pending   = 8'd0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        en       = 1'b0;
        in1      = 4'd0;
        in2      = 4'd0;
        ops      = 2'b00;
        rst_n    = 1'b0;
        modelReset();
        #12;
        checkAll("reset");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b1, 4'd5, 4'd7, 2'b00, "add5p7");
        checkOutput("add5p7.lit", total, 8'd12);
        applyStimulus(1'b1, 4'd8, 4'd3, 2'b01, "sub8m3");
        checkOutput("sub8m3.lit", total, 8'd5);
        applyStimulus(1'b1, 4'd3, 4'd8, 2'b01, "sub3m8");
        checkOutput("sub3m8.lit", total, 8'hFB);
        applyStimulus(1'b1, 4'd4, 4'd6, 2'b10, "mul4x6");
        checkOutput("mul4x6.lit", total, 8'd24);
        applyStimulus(1'b1, 4'd15, 4'd15, 2'b10, "mul15x15");
        checkOutput("mul15x15.lit", total, 8'd225);
        applyStimulus(1'b1, 4'd15, 4'd15, 2'b00, "add15p15");

        applyStimulus(1'b1, 4'd12, 4'd3, 2'b11, "div12d3.acc");
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 4'($urandom), 4'($urandom), 2'($urandom), "div12d3.busy");
        checkOutput("div12d3.lit", total, 8'd4);
        applyStimulus(1'b0, 4'd0, 4'd0, 2'b00, "div12d3.idle");

        applyStimulus(1'b1, 4'd13, 4'd3, 2'b11, "div13d3.acc");
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 4'd0, 4'd0, 2'b00, "div13d3.busy");

        applyStimulus(1'b1, 4'd9, 4'd0, 2'b11, "div9d0");
        checkOutput("div9d0.lit", total, 8'hFF);
        applyStimulus(1'b0, 4'd1, 4'd1, 2'b00, "div9d0.hold");
        applyStimulus(1'b1, 4'd1, 4'd1, 2'b00, "errclear");

        applyStimulus(1'b1, 4'd12, 4'd3, 2'b11, "abort.acc");
        applyStimulus(1'b0, 4'd0, 4'd0, 2'b00, "abort.busy");
        @(negedge clk);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkAll("abort.rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 4'd0, 4'd0, 2'b00, "abort.after");

        for (int i = 0; i < 400; i++) begin
            logic [3:0] b;
            b = 4'($urandom);
            if ($urandom_range(0, 7) == 0) b = 4'd0;
            applyStimulus(($urandom_range(0, 9) < 7), 4'($urandom), b, 2'($urandom), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
